mii_hexdump: RTL and testbench

Formatter stage between the MII byte path and the UART transmitter: captures received bytes and frame-end markers into an internal FIFO and drains them to `uart_tx` as uppercase ASCII hex text. Each frame prints as lines of `BYTES_PER_LINE` space-separated byte pairs, followed by a blank line. The block gives the serial dump a readable, frame-delimited format without the upstream stage ever stalling.

---
 rtl/mii_hexdump.sv | 168 ++++++++++++++++
 tb/tb_mii_hexdump.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_hexdump.sv
// mii_hexdump: buffers MII bytes and frame-end markers, then streams them to a
// UART transmitter as uppercase ASCII hex, BYTES_PER_LINE pairs per line.
`default_nettype none

module mii_hexdump #(
  parameter int FIFO_DEPTH     = 128,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_dv,
  input  logic [7:0] in_d,
  input  logic       in_eof,
  input  logic       tx_active,
  output logic       tx_dv,
  output logic [7:0] tx_d,
  output logic       overflow
);

  localparam int              AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0]   c_DEPTH = (AW+2)'(FIFO_DEPTH);
  localparam logic [AW+1:0]   c_ONE   = (AW+2)'(1);
  localparam logic [AW+1:0]   c_TWO   = (AW+2)'(2);
  localparam logic [7:0]      c_BPL   = 8'(BYTES_PER_LINE);
  localparam logic [7:0]      c_CR    = 8'h0D;
  localparam logic [7:0]      c_LF    = 8'h0A;
  localparam logic [7:0]      c_SP    = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_WAIT} state_t;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic            r_ovf;
  state_t          r_state, w_state_nxt;
  logic [3:0][7:0] r_seq, w_seq_nxt;
  logic [2:0]      r_len, w_len_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_col, w_col_nxt;
  logic            r_tx_dv, w_tx_dv_nxt;
  logic [7:0]      r_tx_d, w_tx_d_nxt;

  logic [AW:0]     w_count;
  logic [AW+1:0]   w_free;
  logic            w_pop, w_wr_byte, w_wr_eof, w_drop, w_avail;
  logic [AW:0]     w_eof_ptr;
  logic [8:0]      w_entry;
  logic [7:0]      w_hi, w_lo;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a write.
  always_comb begin
    w_count   = r_wptr - r_rptr;
    w_pop     = (r_state == S_FETCH);
    w_free    = c_DEPTH - {1'b0, w_count} + {{(AW+1){1'b0}}, w_pop};
    w_wr_byte = in_dv && (w_free >= c_ONE);
    w_wr_eof  = in_eof && (w_free >= (in_dv ? c_TWO : c_ONE));
    w_drop    = (in_dv && !w_wr_byte) || (in_eof && !w_wr_eof);
    w_eof_ptr = r_wptr + {{AW{1'b0}}, w_wr_byte};
  end

  assign w_avail = (w_count != '0) || w_wr_byte || w_wr_eof;
  assign w_entry = r_mem[r_rptr[AW-1:0]];
  assign w_hi    = f_hex(w_entry[7:4]);
  assign w_lo    = f_hex(w_entry[3:0]);

  always_ff @(posedge clk) begin
    if (w_wr_byte) r_mem[r_wptr[AW-1:0]]    <= {1'b0, in_d};
    if (w_wr_eof)  r_mem[w_eof_ptr[AW-1:0]] <= 9'h100;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_wptr <= r_wptr + {{AW{1'b0}}, w_wr_byte} + {{AW{1'b0}}, w_wr_eof};
      r_rptr <= r_rptr + {{AW{1'b0}}, w_pop};
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_seq   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_col   <= '0;
      r_tx_dv <= 1'b0;
      r_tx_d  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_seq   <= w_seq_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_col   <= w_col_nxt;
      r_tx_dv <= w_tx_dv_nxt;
      r_tx_d  <= w_tx_d_nxt;
    end
  end

  // Character sequences are stored first-character-in-lane-0.
  always_comb begin
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_col_nxt   = r_col;
    w_tx_dv_nxt = 1'b0;
    w_tx_d_nxt  = r_tx_d;
    case (r_state)
      S_IDLE: begin
        if (w_avail) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_idx_nxt   = 3'd0;
        w_state_nxt = S_EMIT;
        if (w_entry[8]) begin
          w_col_nxt = 8'd0;
          if (r_col != 8'd0) begin
            w_seq_nxt = {c_LF, c_CR, c_LF, c_CR};
            w_len_nxt = 3'd4;
          end else begin
            w_seq_nxt = {8'h00, 8'h00, c_LF, c_CR};
            w_len_nxt = 3'd2;
          end
        end else if (r_col == 8'd0) begin
          w_seq_nxt = {8'h00, 8'h00, w_lo, w_hi};
          w_len_nxt = 3'd2;
          w_col_nxt = 8'd1;
        end else if (r_col == c_BPL) begin
          w_seq_nxt = {w_lo, w_hi, c_LF, c_CR};
          w_len_nxt = 3'd4;
          w_col_nxt = 8'd1;
        end else begin
          w_seq_nxt = {8'h00, w_lo, w_hi, c_SP};
          w_len_nxt = 3'd3;
          w_col_nxt = r_col + 8'd1;
        end
      end
      S_EMIT: begin
        if (!tx_active) begin
          w_tx_dv_nxt = 1'b1;
          w_tx_d_nxt  = r_seq[r_idx[1:0]];
          w_idx_nxt   = r_idx + 3'd1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_idx != r_len) w_state_nxt = S_EMIT;
        else if (w_avail)   w_state_nxt = S_FETCH;
        else                w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_dv    = r_tx_dv;
  assign tx_d     = r_tx_d;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mii_hexdump.sv
// Bench for mii_hexdump: emulated UART busy window, text-level reference formatter.
`default_nettype none

module tb_mii_hexdump;

  localparam int DEPTH    = 128;
  localparam int BPL      = 16;
  localparam int UART_CYC = 4;

  logic       clk;
  logic       reset_n;
  logic       in_dv;
  logic [7:0] in_d;
  logic       in_eof;
  logic       tx_active;
  logic       tx_dv;
  logic [7:0] tx_d;
  logic       overflow;

  mii_hexdump #(.FIFO_DEPTH(DEPTH), .BYTES_PER_LINE(BPL)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_dv     (in_dv),
    .in_d      (in_d),
    .in_eof    (in_eof),
    .tx_active (tx_active),
    .tx_dv     (tx_dv),
    .tx_d      (tx_d),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         m_col   = 0;
  string      hexs    = "0123456789ABCDEF";

  // UART stand-in: busy for UART_CYC cycles starting one edge after tx_dv.
  int   uart_cnt = 0;
  logic hold     = 1'b0;
  int   b2b      = 0;
  logic prev_dv  = 1'b0;
  assign tx_active = hold || (uart_cnt != 0);

  always @(posedge clk) begin
    if (tx_dv)             uart_cnt <= UART_CYC;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end

  always @(negedge clk) begin
    if (tx_dv) got_q.push_back(tx_d);
    if (tx_dv && prev_dv) b2b <= b2b + 1;
    prev_dv <= tx_dv;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference formatter: appends the text one entry produces (256 = end of frame).
  task automatic model_push(input int e);
    if (e == 256) begin
      if (m_col != 0) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_col = 0;
    end else begin
      if (m_col == BPL) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        m_col = 0;
      end else if (m_col != 0) begin
        exp_q.push_back(8'h20);
      end
      exp_q.push_back(hexs[e / 16]);
      exp_q.push_back(hexs[e % 16]);
      m_col++;
    end
  endtask

  task automatic send(input logic dv, input logic [7:0] d, input logic eof);
    @(negedge clk);
    in_dv  = dv;
    in_d   = d;
    in_eof = eof;
    if (dv)  model_push(int'(d));
    if (eof) model_push(256);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_dv  = 1'b0;
    in_eof = 1'b0;
    in_d   = 8'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input int exp_len);
    int budget;
    budget = 30000;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (40) @(negedge clk);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    if (exp_len >= 0) chk({tag, "_nchar"}, got_q.size(), exp_len);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_c%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int len;
    logic [7:0] v;

    reset_n = 1'b0;
    in_dv   = 1'b0;
    in_d    = 8'h00;
    in_eof  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", tx_dv, 0);
    chk("rst_tx_d", tx_d, 8'h00);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte with latency check
    send(1'b1, 8'hA5, 1'b0);
    idle(1);
    chk("lat_c1", tx_dv, 0);
    @(negedge clk);
    chk("lat_c2", tx_dv, 0);
    @(negedge clk);
    chk("lat_c3", tx_dv, 1);
    send(1'b0, 8'h00, 1'b1);
    idle(1);
    check_stream("single", 6);
    chk("single_ovf", overflow, 0);

    // line wrap
    for (int i = 0; i <= 16; i++) send(1'b1, 8'(i), 1'b0);
    send(1'b0, 8'h00, 1'b1);
    idle(1);
    check_stream("wrap", 55);

    // eof only
    send(1'b0, 8'h00, 1'b1);
    idle(1);
    check_stream("eofonly", 2);

    // simultaneous strobes
    send(1'b1, 8'h3C, 1'b1);
    idle(1);
    check_stream("simul", 6);

    // overflow, twice so the pointers wrap
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      hold = 1'b1;
      send(1'b1, 8'h11, 1'b0);
      idle(8);
      for (int i = 0; i < DEPTH + 2; i++) begin
        @(negedge clk);
        if (i == DEPTH && r == 0) chk("ovf_before", overflow, 0);
        if (i == DEPTH + 1)       chk("ovf_after", overflow, 1);
        v = 8'($urandom_range(0, 255));
        in_dv = 1'b1;
        in_d  = v;
        if (i < DEPTH) model_push(int'(v));
      end
      idle(1);
      chk("ovf_sticky", overflow, 1);
      hold = 1'b0;
      repeat (80) @(negedge clk);
      send(1'b0, 8'h00, 1'b1);
      idle(1);
      check_stream($sformatf("ovf%0d", r), -1);
    end

    // reset between HI and LO characters
    send(1'b1, 8'h5A, 1'b0);
    idle(1);
    begin
      int budget;
      budget = 200;
      while (got_q.size() == 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_dv", tx_dv, 0);
    chk("midrst_ovf", overflow, 0);
    exp_q.delete();
    exp_q.push_back(8'h35);
    m_col = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_quiet", got_q.size(), 1);
    send(1'b1, 8'h7E, 1'b0);
    send(1'b0, 8'h00, 1'b1);
    idle(1);
    check_stream("midrst", 7);

    // random frames
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) begin
        v = 8'($urandom_range(0, 255));
        if (i == len - 1 && $urandom_range(0, 1) == 1) begin
          send(1'b1, v, 1'b1);
        end else begin
          send(1'b1, v, 1'b0);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
      end
      if (m_col != 0 || len == 0) send(1'b0, 8'h00, 1'b1);
      idle(1);
      check_stream($sformatf("rnd%0d", f), -1);
    end

    chk("end_ovf", overflow, 0);
    chk("no_back2back", b2b, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
